wb_sequencer: RTL and testbench

//  Write-back sequencer: the write-side master of the register file's single write port.

---
 rtl/wb_sequencer_if.sv | 38 +++
 rtl/wb_sequencer.sv | 97 +++++++++
 tb/tb_wb_sequencer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/wb_sequencer_if.sv
// Bundle of producer, scoreboard and register-file write signals around wb_sequencer.
// master is the sequencer's own view (it masters the write port); slave is the surrounding pipeline.
interface wb_sequencer_if #(
    parameter int N     = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    // valid/ready: a result transfers at a posedge where valid && ready are both 1;
    // while valid && !ready the producer holds rd/data unchanged.
    logic          alu_valid;
    logic [4:0]    alu_rd;
    logic [N-1:0]  alu_data;
    logic          alu_ready;
    logic          mem_valid;
    logic [4:0]    mem_rd;
    logic [N-1:0]  mem_data;
    logic          mem_ready;
    logic          issue_valid;
    logic [4:0]    issue_rd;
    logic [4:0]    a3;
    logic [N-1:0]  wd3;
    logic          we;
    logic [31:0]   busy;
    logic [CW-1:0] count;

    modport master (
        input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        input  issue_valid, issue_rd,
        output alu_ready, mem_ready, a3, wd3, we, busy, count
    );

    modport slave (
        output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        output issue_valid, issue_rd,
        input  alu_ready, mem_ready, a3, wd3, we, busy, count
    );
endinterface

// File: rtl/wb_sequencer.sv
// Write-back sequencer: in-order queue from ALU and load unit into the single register-file
// write port, plus a busy scoreboard of outstanding load destinations.
module wb_sequencer #(
    parameter int N     = 32,
    parameter int DEPTH = 4
) (
    input logic           clk,
    input logic           rst_n,
    wb_sequencer_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL   = CW'(DEPTH);
    localparam logic [CW-1:0] ALMOST = CW'(DEPTH - 1);

    logic [4:0]       rd_q   [DEPTH];
    logic [N-1:0]     data_q [DEPTH];
    logic [DEPTH-1:0] src_q;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_r;
    logic             we_r;
    logic [4:0]       a3_r;
    logic [N-1:0]     wd3_r;
    logic [31:0]      busy_r;

    logic             mem_push;
    logic             alu_push;
    logic             pop;
    logic [PW-1:0]    alu_slot;
    logic [CW-1:0]    count_next;
    logic [31:0]      busy_next;

    // Readies ignore a same-cycle pop; the ALU only gets the last slot when the load unit is idle.
    assign bus.mem_ready = !rst_n || (count_r < FULL);
    assign bus.alu_ready = !rst_n || (count_r < ALMOST) ||
                           ((count_r == ALMOST) && !bus.mem_valid);

    assign bus.we    = we_r;
    assign bus.a3    = a3_r;
    assign bus.wd3   = wd3_r;
    assign bus.busy  = busy_r;
    assign bus.count = count_r;

    // x0 writes complete the handshake but never occupy a slot.
    assign mem_push = bus.mem_valid && bus.mem_ready && (bus.mem_rd != 5'd0);
    assign alu_push = bus.alu_valid && bus.alu_ready && (bus.alu_rd != 5'd0);
    assign pop      = (count_r != '0);
    assign alu_slot = mem_push ? wr_ptr + PW'(1) : wr_ptr;

    always_comb begin
        count_next = count_r + CW'(mem_push) + CW'(alu_push) - CW'(pop);
    end

    always_comb begin
        busy_next = busy_r;
        if (pop && src_q[rd_ptr]) begin
            busy_next[rd_q[rd_ptr]] = 1'b0;
        end
        if (bus.issue_valid && (bus.issue_rd != 5'd0)) begin
            busy_next[bus.issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_r <= '0;
            we_r    <= 1'b0;
            a3_r    <= 5'd0;
            wd3_r   <= '0;
            busy_r  <= '0;
        end else begin
            if (mem_push) begin
                rd_q[wr_ptr]   <= bus.mem_rd;
                data_q[wr_ptr] <= bus.mem_data;
                src_q[wr_ptr]  <= 1'b1;
            end
            if (alu_push) begin
                rd_q[alu_slot]   <= bus.alu_rd;
                data_q[alu_slot] <= bus.alu_data;
                src_q[alu_slot]  <= 1'b0;
            end
            wr_ptr  <= wr_ptr + PW'(mem_push) + PW'(alu_push);
            rd_ptr  <= rd_ptr + PW'(pop);
            count_r <= count_next;
            we_r    <= pop;
            if (pop) begin
                a3_r  <= rd_q[rd_ptr];
                wd3_r <= data_q[rd_ptr];
            end
            busy_r <= busy_next;
        end
    end
endmodule

// File: tb/tb_wb_sequencer.sv
// Bench for wb_sequencer: directed vector table, a saturation sequence and a randomized
// run, all checked against an ordered queue-based model of the write-back rules.
module tb_wb_sequencer;
    localparam int N     = 32;
    localparam int DEPTH = 4;
    localparam int W     = 1 + 5 + N;

    logic clk;
    logic rst_n;

    wb_sequencer_if #(.N(N), .DEPTH(DEPTH)) bus ();

    wb_sequencer #(.N(N), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: pending writes as {src, rd, data}, in acceptance order.
    logic [W-1:0] exp_q[$];
    logic         m_we;
    logic [4:0]   m_a3;
    logic [N-1:0] m_wd3;
    logic [31:0]  m_busy;

    int n_checks;
    int n_pass;

    typedef struct {
        logic        r;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] md;
        logic        iv;
        logic [4:0]  ird;
        logic        ear;
        logic        emr;
        logic        ewe;
        logic [4:0]  ea3;
        logic [31:0] ewd3;
        logic [2:0]  ecnt;
        logic [31:0] ebusy;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // One clock: drive, check readies, clock, update model, check registered outputs.
    task automatic step(input logic r, input logic av, input logic [4:0] ard, input logic [31:0] ad,
                        input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                        input logic iv, input logic [4:0] ird,
                        output logic ar_s, output logic mr_s,
                        output logic acc_a, output logic acc_m);
        logic         exp_ar;
        logic         exp_mr;
        logic [W-1:0] head;
        int           sz;
        rst_n           = r;
        bus.alu_valid   = av;
        bus.alu_rd      = ard;
        bus.alu_data    = ad;
        bus.mem_valid   = mv;
        bus.mem_rd      = mrd;
        bus.mem_data    = md;
        bus.issue_valid = iv;
        bus.issue_rd    = ird;
        #1;
        sz     = exp_q.size();
        exp_mr = !r || (sz < DEPTH);
        exp_ar = !r || (sz < DEPTH - 1) || ((sz == DEPTH - 1) && !mv);
        ar_s   = bus.alu_ready;
        mr_s   = bus.mem_ready;
        check("alu_ready", {31'd0, ar_s}, {31'd0, exp_ar});
        check("mem_ready", {31'd0, mr_s}, {31'd0, exp_mr});
        acc_a = av && exp_ar;
        acc_m = mv && exp_mr;
        @(posedge clk);
        if (!r) begin
            exp_q.delete();
            m_we   = 1'b0;
            m_a3   = 5'd0;
            m_wd3  = '0;
            m_busy = '0;
        end else begin
            if (exp_q.size() > 0) begin
                head  = exp_q.pop_front();
                m_we  = 1'b1;
                m_a3  = head[N+4:N];
                m_wd3 = head[N-1:0];
                if (head[W-1]) m_busy[head[N+4:N]] = 1'b0;
            end else begin
                m_we = 1'b0;
            end
            if (acc_m && mrd != 5'd0) exp_q.push_back({1'b1, mrd, md});
            if (acc_a && ard != 5'd0) exp_q.push_back({1'b0, ard, ad});
            if (iv && ird != 5'd0) m_busy[ird] = 1'b1;
        end
        #1;
        check("we", {31'd0, bus.we}, {31'd0, m_we});
        check("a3", {27'd0, bus.a3}, {27'd0, m_a3});
        check("wd3", bus.wd3, m_wd3);
        check("count", {29'd0, bus.count}, exp_q.size());
        check("busy", bus.busy, m_busy);
    endtask

    task automatic idle(input int cycles);
        logic ar, mr, aa, am;
        for (int i = 0; i < cycles; i++) begin
            step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, ar, mr, aa, am);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        ar, mr, aa, am;
        logic        p_av, p_mv, iv, r;
        logic [4:0]  p_ard, p_mrd, ird;
        logic [31:0] p_ad, p_md;
        logic        stalled;
        int          peak;
        int          next_rd;

        n_checks = 0;
        n_pass   = 0;
        m_we     = 1'b0;
        m_a3     = 5'd0;
        m_wd3    = '0;
        m_busy   = '0;
        rst_n    = 1'b0;

        //            r av ard  ad             mv mrd md          iv ird  ear emr we a3  wd3           cnt busy
        vecs[0]  = '{0, 1, 3,  32'h1,         1, 4,  32'h2,      1, 5,   1, 1, 0, 0,  32'h0,        0, 32'h0};
        vecs[1]  = '{0, 1, 3,  32'h1,         1, 4,  32'h2,      1, 5,   1, 1, 0, 0,  32'h0,        0, 32'h0};
        vecs[2]  = '{1, 1, 5,  32'h12345678,  0, 0,  32'h0,      0, 0,   1, 1, 0, 0,  32'h0,        1, 32'h0};
        vecs[3]  = '{1, 0, 0,  32'h0,         0, 0,  32'h0,      0, 0,   1, 1, 1, 5,  32'h12345678, 0, 32'h0};
        vecs[4]  = '{1, 0, 0,  32'h0,         0, 0,  32'h0,      0, 0,   1, 1, 0, 5,  32'h12345678, 0, 32'h0};
        vecs[5]  = '{1, 1, 7,  32'hB,         1, 6,  32'hA,      0, 0,   1, 1, 0, 5,  32'h12345678, 2, 32'h0};
        vecs[6]  = '{1, 0, 0,  32'h0,         0, 0,  32'h0,      0, 0,   1, 1, 1, 6,  32'hA,        1, 32'h0};
        vecs[7]  = '{1, 0, 0,  32'h0,         0, 0,  32'h0,      0, 0,   1, 1, 1, 7,  32'hB,        0, 32'h0};
        vecs[8]  = '{1, 1, 0,  32'hFFFFFFFF,  0, 0,  32'h0,      1, 0,   1, 1, 0, 7,  32'hB,        0, 32'h0};
        vecs[9]  = '{1, 0, 0,  32'h0,         0, 0,  32'h0,      0, 0,   1, 1, 0, 7,  32'hB,        0, 32'h0};
        vecs[10] = '{1, 0, 0,  32'h0,         0, 0,  32'h0,      1, 9,   1, 1, 0, 7,  32'hB,        0, 32'h200};
        vecs[11] = '{1, 1, 9,  32'h99,        0, 0,  32'h0,      0, 0,   1, 1, 0, 7,  32'hB,        1, 32'h200};
        vecs[12] = '{1, 0, 0,  32'h0,         0, 0,  32'h0,      0, 0,   1, 1, 1, 9,  32'h99,       0, 32'h200};
        vecs[13] = '{1, 0, 0,  32'h0,         1, 9,  32'h77,     0, 0,   1, 1, 0, 9,  32'h99,       1, 32'h200};
        vecs[14] = '{1, 0, 0,  32'h0,         0, 0,  32'h0,      0, 0,   1, 1, 1, 9,  32'h77,       0, 32'h0};
        vecs[15] = '{1, 0, 0,  32'h0,         1, 9,  32'h55,     0, 0,   1, 1, 0, 9,  32'h77,       1, 32'h0};
        vecs[16] = '{1, 0, 0,  32'h0,         0, 0,  32'h0,      1, 9,   1, 1, 1, 9,  32'h55,       0, 32'h200};
        vecs[17] = '{1, 0, 0,  32'h0,         0, 0,  32'h0,      0, 0,   1, 1, 0, 9,  32'h55,       0, 32'h200};
        vecs[18] = '{1, 1, 11, 32'h2,         1, 10, 32'h1,      0, 0,   1, 1, 0, 9,  32'h55,       2, 32'h200};
        vecs[19] = '{1, 1, 12, 32'h3,         1, 13, 32'h4,      0, 0,   1, 1, 1, 10, 32'h1,        3, 32'h200};
        vecs[20] = '{0, 1, 14, 32'h5,         1, 15, 32'h6,      1, 16,  1, 1, 0, 0,  32'h0,        0, 32'h0};
        vecs[21] = '{1, 0, 0,  32'h0,         0, 0,  32'h0,      0, 0,   1, 1, 0, 0,  32'h0,        0, 32'h0};
        vecs[22] = '{1, 0, 0,  32'h0,         0, 0,  32'h0,      0, 0,   1, 1, 0, 0,  32'h0,        0, 32'h0};

        for (int i = 0; i < NV; i++) begin
            step(vecs[i].r, vecs[i].av, vecs[i].ard, vecs[i].ad, vecs[i].mv, vecs[i].mrd, vecs[i].md,
                 vecs[i].iv, vecs[i].ird, ar, mr, aa, am);
            check($sformatf("v%0d_alu_ready", i), {31'd0, ar}, {31'd0, vecs[i].ear});
            check($sformatf("v%0d_mem_ready", i), {31'd0, mr}, {31'd0, vecs[i].emr});
            check($sformatf("v%0d_we", i), {31'd0, bus.we}, {31'd0, vecs[i].ewe});
            check($sformatf("v%0d_a3", i), {27'd0, bus.a3}, {27'd0, vecs[i].ea3});
            check($sformatf("v%0d_wd3", i), bus.wd3, vecs[i].ewd3);
            check($sformatf("v%0d_count", i), {29'd0, bus.count}, {29'd0, vecs[i].ecnt});
            check($sformatf("v%0d_busy", i), bus.busy, vecs[i].ebusy);
        end

        // Both producers always valid with distinct destinations; each holds until accepted.
        stalled = 1'b0;
        peak    = 0;
        next_rd = 1;
        p_av    = 1'b0;
        p_mv    = 1'b0;
        p_ard   = 5'd0;
        p_mrd   = 5'd0;
        p_ad    = '0;
        p_md    = '0;
        for (int c = 0; c < 10; c++) begin
            if (!p_mv) begin p_mv = 1'b1; p_mrd = 5'(next_rd); p_md = 32'hA000 + next_rd; next_rd++; end
            if (!p_av) begin p_av = 1'b1; p_ard = 5'(next_rd); p_ad = 32'hB000 + next_rd; next_rd++; end
            step(1'b1, p_av, p_ard, p_ad, p_mv, p_mrd, p_md, 1'b0, 5'd0, ar, mr, aa, am);
            if (!aa) stalled = 1'b1;
            if (int'(bus.count) > peak) peak = int'(bus.count);
            if (aa) p_av = 1'b0;
            if (am) p_mv = 1'b0;
        end
        check("t4_alu_stalled", {31'd0, stalled}, 32'd1);
        check("t4_peak_count", peak, DEPTH - 1);
        if (p_mv) step(1'b1, 1'b0, 5'd0, 32'd0, p_mv, p_mrd, p_md, 1'b0, 5'd0, ar, mr, aa, am);
        if (p_av) step(1'b1, p_av, p_ard, p_ad, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, ar, mr, aa, am);
        idle(6);
        check("t4_drained", {29'd0, bus.count}, 32'd0);

        // Randomized traffic with occasional resets.
        p_av = 1'b0;
        p_mv = 1'b0;
        for (int c = 0; c < 500; c++) begin
            if (!p_av && $urandom_range(0, 99) < 60) begin
                p_av  = 1'b1;
                p_ard = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                p_ad  = $urandom;
            end
            if (!p_mv && $urandom_range(0, 99) < 50) begin
                p_mv  = 1'b1;
                p_mrd = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                p_md  = $urandom;
            end
            iv  = ($urandom_range(0, 99) < 30);
            ird = 5'($urandom_range(0, 31));
            r   = ($urandom_range(0, 149) != 0);
            step(r, p_av, p_ard, p_ad, p_mv, p_mrd, p_md, iv, ird, ar, mr, aa, am);
            if (aa) p_av = 1'b0;
            if (am) p_mv = 1'b0;
        end
        idle(6);
        check("final_drained", {29'd0, bus.count}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
